// File: rtl/datapath_bist.sv
// Built-in self-test sequencer: fetches directed vectors from a ROM, drives them into the
// single-cycle datapath one per EXEC cycle and scores ALUResult/zero. Optional PC check: DATAPATH_BIST_PC_CHECK_EN.
module datapath_bist #(
    parameter int XLEN      = 32,
    parameter int NUM_TESTS = 8,
    parameter int AW        = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1,
    parameter int CW        = $clog2(NUM_TESTS + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [AW-1:0]   vec_addr,
    input  logic [31:0]     vec_instr,
    input  logic [13:0]     vec_ctrl,
    input  logic [XLEN-1:0] vec_rdata,
    input  logic [XLEN-1:0] vec_expect,
    output logic [31:0]     instr,
    output logic            PCSrc,
    output logic [1:0]      ResultSrc,
    output logic            ALUSrc,
    output logic [2:0]      ImmSrc,
    output logic            RegWrite,
    output logic [3:0]      ALUControl,
    output logic [XLEN-1:0] ReadData,
    input  logic [XLEN-1:0] PC,
    input  logic [XLEN-1:0] ALUResult,
    input  logic            zero,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [CW-1:0]   pass_count,
    output logic [CW-1:0]   fail_count,
    output logic [AW-1:0]   first_fail
);

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_DRAIN, S_DONE} state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   idx;
    logic            last_vec;
    logic            run_start;

    logic [XLEN-1:0] expect_p1;
    logic            chk_en_p1;
    logic            zero_exp_p1;

    logic            alu_pass, alu_fail, pc_fail, any_fail;
    logic [AW-1:0]   pc_idx, fail_idx;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign last_vec  = (idx == AW'(NUM_TESTS - 1));
    assign run_start = start && ((state == S_IDLE) || (state == S_DONE));
    assign vec_addr  = idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        pass      = 1'b0;
        case (state)
            S_IDLE:  if (start) state_nxt = S_FETCH;
            S_FETCH: begin
                busy      = 1'b1;
                state_nxt = S_EXEC;
            end
            S_EXEC: begin
                busy      = 1'b1;
                state_nxt = last_vec ? S_DRAIN : S_FETCH;
            end
            S_DRAIN: begin
                busy      = 1'b1;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                pass = (fail_count == '0);
                if (start) state_nxt = S_FETCH;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                              idx <= '0;
        else if (run_start)                   idx <= '0;
        else if (state == S_EXEC && !last_vec) idx <= idx + 1'b1;
    end

    // FETCH -> EXEC boundary: vector becomes the datapath drive for one cycle (p1)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr      <= NOP_INSTR;
            PCSrc      <= 1'b0;
            ResultSrc  <= '0;
            ALUSrc     <= 1'b0;
            ImmSrc     <= '0;
            RegWrite   <= 1'b0;
            ALUControl <= '0;
            ReadData   <= '0;
        end else if (state == S_FETCH) begin
            instr      <= vec_instr;
            PCSrc      <= vec_ctrl[11];
            ResultSrc  <= vec_ctrl[10:9];
            ALUSrc     <= vec_ctrl[8];
            ImmSrc     <= vec_ctrl[7:5];
            RegWrite   <= vec_ctrl[4];
            ALUControl <= vec_ctrl[3:0];
            ReadData   <= vec_rdata;
        end else begin
            instr      <= NOP_INSTR;
            PCSrc      <= 1'b0;
            ResultSrc  <= '0;
            ALUSrc     <= 1'b0;
            ImmSrc     <= '0;
            RegWrite   <= 1'b0;
            ALUControl <= '0;
            ReadData   <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_FETCH) begin
            expect_p1   <= vec_expect;
            chk_en_p1   <= vec_ctrl[13];
            zero_exp_p1 <= vec_ctrl[12];
        end
    end

    assign alu_pass = (state == S_EXEC) && chk_en_p1 &&
                      (ALUResult == expect_p1) && (zero == zero_exp_p1);
    assign alu_fail = (state == S_EXEC) && chk_en_p1 &&
                      !((ALUResult == expect_p1) && (zero == zero_exp_p1));

`ifdef DATAPATH_BIST_PC_CHECK_EN
    // EXEC -> FETCH/DRAIN boundary: remember the EXEC-cycle PC for the follow-up check (p2)
    logic            pc_vld_p2;
    logic            pcsrc_p2;
    logic [XLEN-1:0] pc_p2;
    logic [AW-1:0]   idx_p2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pc_vld_p2 <= 1'b0;
        else     pc_vld_p2 <= (state == S_EXEC);
    end

    always_ff @(posedge clk) begin
        if (state == S_EXEC) begin
            pc_p2    <= PC;
            pcsrc_p2 <= PCSrc;
            idx_p2   <= idx;
        end
    end

    assign pc_fail = pc_vld_p2 &&
                     (pcsrc_p2 ? (PC == pc_p2) : (PC != pc_p2 + XLEN'(4)));
    assign pc_idx  = idx_p2;
`else
    logic unused_pc;
    assign unused_pc = ^PC;
    assign pc_fail   = 1'b0;
    assign pc_idx    = '0;
`endif

    // ALU failures occur only in EXEC and PC failures only in FETCH/DRAIN, so they never collide
    assign any_fail = alu_fail || pc_fail;
    assign fail_idx = alu_fail ? idx : pc_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass_count <= '0;
            fail_count <= '0;
            first_fail <= '0;
        end else if (run_start) begin
            pass_count <= '0;
            fail_count <= '0;
            first_fail <= '0;
        end else begin
            if (alu_pass) pass_count <= sat_inc(pass_count);
            if (any_fail) begin
                fail_count <= sat_inc(fail_count);
                if (fail_count == '0) first_fail <= fail_idx;
            end
        end
    end

endmodule

// File: tb/tb_datapath_bist.sv
// Self-checking bench for datapath_bist: ROM and datapath behavioural models plus a
// reference scorer that re-executes each vector's instruction semantics.
module tb_datapath_bist;

    localparam int XLEN = 32;
    localparam int N    = 4;
    localparam int AW   = 2;
    localparam int CW   = 3;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic            clk = 1'b0;
    logic            rst, start;
    logic [AW-1:0]   vec_addr;
    logic [31:0]     vec_instr;
    logic [13:0]     vec_ctrl;
    logic [XLEN-1:0] vec_rdata, vec_expect;
    logic [31:0]     instr;
    logic            PCSrc, ALUSrc, RegWrite, zero;
    logic [1:0]      ResultSrc;
    logic [2:0]      ImmSrc;
    logic [3:0]      ALUControl;
    logic [XLEN-1:0] ReadData, PC, ALUResult;
    logic            busy, done, pass;
    logic [CW-1:0]   pass_count, fail_count;
    logic [AW-1:0]   first_fail;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    datapath_bist #(.XLEN(XLEN), .NUM_TESTS(N), .AW(AW), .CW(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .vec_addr(vec_addr),
        .vec_instr(vec_instr), .vec_ctrl(vec_ctrl), .vec_rdata(vec_rdata),
        .vec_expect(vec_expect), .instr(instr), .PCSrc(PCSrc), .ResultSrc(ResultSrc),
        .ALUSrc(ALUSrc), .ImmSrc(ImmSrc), .RegWrite(RegWrite), .ALUControl(ALUControl),
        .ReadData(ReadData), .PC(PC), .ALUResult(ALUResult), .zero(zero),
        .busy(busy), .done(done), .pass(pass), .pass_count(pass_count),
        .fail_count(fail_count), .first_fail(first_fail)
    );

    // Vector ROM (contents) and the per-vector semantics used by the reference scorer
    logic [31:0]     rom_instr  [N];
    logic [13:0]     rom_ctrl   [N];
    logic [XLEN-1:0] rom_rdata  [N];
    logic [XLEN-1:0] rom_expect [N];
    int              op_k [N];   // 0 addi, 1 add, 2 sub
    int              rd_k [N], rs1_k [N], rs2_k [N];
    logic [31:0]     imm_k [N];
    logic            chk_k [N], zexp_k [N];
    logic [31:0]     truth_res [N];

    assign vec_instr  = rom_instr[vec_addr];
    assign vec_ctrl   = rom_ctrl[vec_addr];
    assign vec_rdata  = rom_rdata[vec_addr];
    assign vec_expect = rom_expect[vec_addr];

    // Datapath model: decodes the driven instruction and commits on the clock edge
    logic [31:0] rf [32];
    logic [31:0] pc_q;
    logic        pc_stuck;
    logic [31:0] src_a, src_b;

    assign src_a     = rf[instr[19:15]];
    assign src_b     = ALUSrc ? {{20{instr[31]}}, instr[31:20]} : rf[instr[24:20]];
    assign ALUResult = (ALUControl == 4'd1) ? src_a - src_b : src_a + src_b;
    assign zero      = (ALUResult == 32'd0);
    assign PC        = pc_q;

    always @(posedge clk) begin
        if (RegWrite && instr[11:7] != 5'd0) rf[instr[11:7]] <= ALUResult;
        if (!pc_stuck) pc_q <= pc_q + 32'd4;
    end

    task automatic set_vec(input int k, input int op, input int rd, input int rs1, input int rs2,
                           input int imm, input logic [31:0] ex, input logic chk, input logic zx);
        logic [11:0] i12;
        logic [4:0]  d, s1, s2;
        i12 = imm[11:0];
        d = 5'(rd); s1 = 5'(rs1); s2 = 5'(rs2);
        op_k[k] = op; rd_k[k] = rd; rs1_k[k] = rs1; rs2_k[k] = rs2;
        imm_k[k] = imm; chk_k[k] = chk; zexp_k[k] = zx;
        rom_expect[k] = ex;
        rom_rdata[k]  = 32'hA5A5_0000 | 32'(k);
        case (op)
            0: begin
                rom_instr[k] = {i12, s1, 3'b000, d, 7'h13};
                rom_ctrl[k]  = {chk, zx, 1'b0, 2'b00, 1'b1, 3'b000, 1'b1, 4'd0};
            end
            1: begin
                rom_instr[k] = {7'h00, s2, s1, 3'b000, d, 7'h33};
                rom_ctrl[k]  = {chk, zx, 1'b0, 2'b00, 1'b0, 3'b000, 1'b1, 4'd0};
            end
            default: begin
                rom_instr[k] = {7'h20, s2, s1, 3'b000, d, 7'h33};
                rom_ctrl[k]  = {chk, zx, 1'b0, 2'b00, 1'b0, 3'b000, 1'b1, 4'd1};
            end
        endcase
    endtask

    task automatic compute_truth();
        logic [31:0] r [32];
        logic [31:0] a, b;
        for (int i = 0; i < 32; i++) r[i] = 32'd0;
        for (int k = 0; k < N; k++) begin
            a = r[rs1_k[k]];
            b = (op_k[k] == 0) ? imm_k[k] : r[rs2_k[k]];
            truth_res[k] = (op_k[k] == 2) ? a - b : a + b;
            if (rd_k[k] != 0) r[rd_k[k]] = truth_res[k];
        end
    endtask

    task automatic predict(output int ep, output int ef, output int eff);
        compute_truth();
        ep = 0; ef = 0; eff = -1;
        for (int k = 0; k < N; k++) begin
            if (chk_k[k]) begin
                if (truth_res[k] == rom_expect[k] && zexp_k[k] == (truth_res[k] == 32'd0)) ep++;
                else begin ef++; if (eff < 0) eff = k; end
            end
`ifdef DATAPATH_BIST_PC_CHECK_EN
            if (pc_stuck) begin ef++; if (eff < 0) eff = k; end
`endif
        end
        if (ep > 7) ep = 7;
        if (ef > 7) ef = 7;
    endtask

    // Pulses start and follows the run edge by edge, tallying drive/busy protocol violations
    task automatic run(input int extra_start_at, output int done_edge, output int drv_bad,
                       output int busy_bad);
        int cyc, k;
        @(negedge clk) start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        done_edge = -1; drv_bad = 0; busy_bad = 0;
        for (int n = 1; n <= 40 && done_edge < 0; n++) begin
            if (n == extra_start_at) @(negedge clk) start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
            cyc = n + 1;
            if (done) done_edge = n;
            if (cyc % 2 == 0 && cyc <= 2 * N) begin
                k = (cyc - 2) / 2;
                if (instr !== rom_instr[k] || RegWrite !== rom_ctrl[k][4] ||
                    ALUSrc !== rom_ctrl[k][8] || ALUControl !== rom_ctrl[k][3:0] ||
                    ReadData !== rom_rdata[k]) drv_bad++;
            end else if (instr !== NOP || RegWrite !== 1'b0 || PCSrc !== 1'b0 ||
                         ReadData !== 32'd0 || ALUControl !== 4'd0) drv_bad++;
            if (cyc % 2 == 1 && cyc <= 2 * N - 1 && vec_addr !== AW'((cyc - 1) / 2)) drv_bad++;
            if (busy !== (cyc <= 2 * N + 1)) busy_bad++;
        end
    endtask

    task automatic load_basic_set(input logic [31:0] exp2);
        set_vec(0, 0, 2, 0, 0, 5,  32'd5,  1'b1, 1'b0);
        set_vec(1, 0, 3, 0, 0, 10, 32'd10, 1'b1, 1'b0);
        set_vec(2, 1, 1, 2, 3, 0,  exp2,   1'b1, 1'b0);
        set_vec(3, 2, 4, 2, 3, 0,  32'hFFFF_FFFB, 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin errors++;
            $display("FAIL reset_status: busy/done/pass=%b%b%b expected 000", busy, done, pass); end
        checks++; if (pass_count !== 3'd0 || fail_count !== 3'd0 || first_fail !== 2'd0) begin errors++;
            $display("FAIL reset_counters: pc=%0d fc=%0d ff=%0d expected 0 0 0", pass_count, fail_count, first_fail); end
        checks++; if (vec_addr !== 2'd0) begin errors++;
            $display("FAIL reset_vec_addr: got %0d expected 0", vec_addr); end
        checks++; if (instr !== NOP) begin errors++;
            $display("FAIL reset_instr: got %h expected %h", instr, NOP); end
        checks++; if ({PCSrc, ResultSrc, ALUSrc, ImmSrc, RegWrite, ALUControl} !== 13'd0 || ReadData !== 32'd0) begin errors++;
            $display("FAIL reset_ctrl: ctrl=%h rd=%h expected 0", {PCSrc, ResultSrc, ALUSrc, ImmSrc, RegWrite, ALUControl}, ReadData); end
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_directed_pass();
        int de, db, bb;
        load_basic_set(32'd15);
        run(0, de, db, bb);
        checks++; if (de !== 2 * N + 1) begin errors++; $display("FAIL pass_done_edge: got %0d expected %0d", de, 2 * N + 1); end
        checks++; if (db !== 0) begin errors++; $display("FAIL pass_drives: %0d bad cycles expected 0", db); end
        checks++; if (bb !== 0) begin errors++; $display("FAIL pass_busy: %0d bad cycles expected 0", bb); end
        checks++; if (pass_count !== 3'd4 || fail_count !== 3'd0) begin errors++;
            $display("FAIL pass_counts: pc=%0d fc=%0d expected 4 0", pass_count, fail_count); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (done !== 1'b1 || pass !== 1'b1) begin errors++;
            $display("FAIL pass_hold: done=%b pass=%b expected 1 1", done, pass); end
    endtask

    task automatic test_directed_fail();
        int de, db, bb;
        load_basic_set(32'd16);
        run(0, de, db, bb);
        checks++; if (fail_count !== 3'd1 || pass_count !== 3'd3) begin errors++;
            $display("FAIL fail_counts: pc=%0d fc=%0d expected 3 1", pass_count, fail_count); end
        checks++; if (first_fail !== 2'd2) begin errors++; $display("FAIL fail_first: got %0d expected 2", first_fail); end
        checks++; if (done !== 1'b1 || pass !== 1'b0) begin errors++;
            $display("FAIL fail_pass: done=%b pass=%b expected 1 0", done, pass); end
    endtask

    task automatic test_zero_and_check_en();
        int de, db, bb;
        set_vec(0, 0, 2, 0, 0, 5, 32'd5, 1'b1, 1'b0);
        set_vec(1, 2, 7, 2, 2, 0, 32'd0, 1'b1, 1'b1);
        set_vec(2, 2, 7, 2, 2, 0, 32'd0, 1'b1, 1'b0);
        set_vec(3, 0, 5, 0, 0, 1, 32'd99, 1'b0, 1'b0);
        run(0, de, db, bb);
        checks++; if (pass_count !== 3'd2 || fail_count !== 3'd1) begin errors++;
            $display("FAIL zero_counts: pc=%0d fc=%0d expected 2 1", pass_count, fail_count); end
        checks++; if (first_fail !== 2'd2) begin errors++; $display("FAIL zero_first: got %0d expected 2", first_fail); end
    endtask

    task automatic test_start_while_busy();
        int de, db, bb;
        load_basic_set(32'd15);
        run(4, de, db, bb);
        checks++; if (de !== 2 * N + 1) begin errors++; $display("FAIL busy_start_done_edge: got %0d expected %0d", de, 2 * N + 1); end
        checks++; if (pass_count !== 3'd4 || fail_count !== 3'd0 || db !== 0) begin errors++;
            $display("FAIL busy_start_run: pc=%0d fc=%0d bad=%0d expected 4 0 0", pass_count, fail_count, db); end
    endtask

    task automatic test_reset_mid_run();
        int de, db, bb;
        load_basic_set(32'd15);
        @(negedge clk) start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || pass_count !== 3'd0 || vec_addr !== 2'd0) begin errors++;
            $display("FAIL abort_state: busy=%b done=%b pc=%0d addr=%0d expected 0 0 0 0", busy, done, pass_count, vec_addr); end
        checks++; if (instr !== NOP || RegWrite !== 1'b0) begin errors++;
            $display("FAIL abort_drives: instr=%h we=%b expected %h 0", instr, RegWrite, NOP); end
        @(negedge clk) rst = 1'b0;
        run(0, de, db, bb);
        checks++; if (de !== 2 * N + 1 || pass_count !== 3'd4 || fail_count !== 3'd0 || db !== 0) begin errors++;
            $display("FAIL abort_rerun: edge=%0d pc=%0d fc=%0d bad=%0d expected %0d 4 0 0", de, pass_count, fail_count, db, 2 * N + 1); end
    endtask

    task automatic test_random();
        int de, db, bb, ep, ef, eff, a, b, s, o;
        for (int r = 0; r < 8; r++) begin
            a = int'($urandom_range(0, 4095)) - 2048;
            b = ($urandom_range(0, 2) == 0) ? a : int'($urandom_range(0, 4095)) - 2048;
            set_vec(0, 0, 2, 0, 0, a, 32'd0, 1'b1, 1'b0);
            set_vec(1, 0, 3, 0, 0, b, 32'd0, 1'b1, 1'b0);
            set_vec(2, int'($urandom_range(1, 2)), int'($urandom_range(1, 31)), 2, 3, 0, 32'd0, 1'b1, 1'b0);
            s = ($urandom_range(0, 1) == 1) ? rd_k[2] : 3;
            set_vec(3, int'($urandom_range(1, 2)), int'($urandom_range(4, 31)), 2, s, 0, 32'd0, 1'b1, 1'b0);
            compute_truth();
            for (int k = 0; k < N; k++) begin
                o = int'($urandom_range(0, 5));
                set_vec(k, op_k[k], rd_k[k], rs1_k[k], rs2_k[k], int'(imm_k[k]),
                        (o == 0) ? truth_res[k] ^ (32'd1 << $urandom_range(0, 31)) : truth_res[k],
                        (o != 1), (o == 2) ^ (truth_res[k] == 32'd0));
            end
            predict(ep, ef, eff);
            run(0, de, db, bb);
            checks++; if (pass_count !== 3'(ep) || fail_count !== 3'(ef)) begin errors++;
                $display("FAIL rand_counts[%0d]: pc=%0d fc=%0d expected %0d %0d", r, pass_count, fail_count, ep, ef); end
            checks++; if (pass !== (ef == 0) || de !== 2 * N + 1) begin errors++;
                $display("FAIL rand_pass[%0d]: pass=%b edge=%0d expected %b %0d", r, pass, de, ef == 0, 2 * N + 1); end
            if (ef > 0) begin
                checks++; if (first_fail !== 2'(eff)) begin errors++;
                    $display("FAIL rand_first[%0d]: got %0d expected %0d", r, first_fail, eff); end
            end
        end
    endtask

`ifdef DATAPATH_BIST_PC_CHECK_EN
    task automatic test_pc_stuck();
        int de, db, bb, ep, ef, eff;
        load_basic_set(32'd15);
        for (int k = 0; k < N; k++) set_vec(k, op_k[k], rd_k[k], rs1_k[k], rs2_k[k], int'(imm_k[k]), rom_expect[k], 1'b0, 1'b0);
        pc_stuck = 1'b1;
        predict(ep, ef, eff);
        run(0, de, db, bb);
        pc_stuck = 1'b0;
        checks++; if (fail_count !== 3'(ef) || pass_count !== 3'(ep) || first_fail !== 2'(eff)) begin errors++;
            $display("FAIL pc_stuck: fc=%0d pc=%0d ff=%0d expected %0d %0d %0d", fail_count, pass_count, first_fail, ef, ep, eff); end
    endtask
`endif

    initial begin
        rst = 1'b1; start = 1'b0; pc_stuck = 1'b0; pc_q = 32'd0;
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        for (int k = 0; k < N; k++) set_vec(k, 0, 0, 0, 0, 0, 32'd0, 1'b0, 1'b0);
        #12;
        test_reset();
        test_directed_pass();
        test_directed_fail();
        test_zero_and_check_en();
        test_start_while_busy();
        test_reset_mid_run();
        test_random();
`ifdef DATAPATH_BIST_PC_CHECK_EN
        test_pc_stuck();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/datapath_bist.md
# datapath_bist

Synthesizable built-in self-test sequencer for the single-cycle RISC-V datapath. It reads directed test vectors (instruction, control word, memory read data, expected ALU result) from an external vector ROM and drives them into the datapath one instruction per cycle. It checks `ALUResult` and `zero` after each instruction and accumulates pass/fail counts. It sits beside `datapath` in the unit-test harness and in the FPGA top, and replaces hand-sequenced benches with a parametrised, reusable checker.

## Interface
- `XLEN`, 32: datapath word width.
- `NUM_TESTS`, 8: number of vectors run per `start`, must be at least 1.
- `AW`, `$clog2(NUM_TESTS)` (minimum 1): vector address width.
- `CW`, `$clog2(NUM_TESTS+1)`: counter width.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset. Asynchronous assert, active-high.
- `start` in 1: one-cycle pulse that begins a run. Ignored unless in IDLE or DONE.
- `vec_addr` out AW: vector ROM address.
- `vec_instr` in 32: instruction, valid 1 cycle after `vec_addr`.
- `vec_ctrl` in 14: control word, packed as {check_en, zero_exp, PCSrc, ResultSrc[1:0], ALUSrc, ImmSrc[2:0], RegWrite, ALUControl[3:0]}.
- `vec_rdata` in XLEN: value driven on the datapath `ReadData` input.
- `vec_expect` in XLEN: expected `ALUResult`.
- `instr` out 32, plus `PCSrc`, `ResultSrc` 2, `ALUSrc`, `ImmSrc` 3, `RegWrite`, `ALUControl` 4, and `ReadData` XLEN, all out: registered drives to the datapath.
- `PC` in XLEN, `ALUResult` in XLEN, `zero` in 1: observed from the datapath.
- `busy` out 1: a run is in progress.
- `done` out 1: the run is complete. Held until the next `start`.
- `pass` out 1: `done` is high and no errors were recorded.
- `pass_count` out CW, `fail_count` out CW: per-vector check results.
- `first_fail` out AW: index of the first failing vector. Valid only when `fail_count` is nonzero.

## Operation
The sequencer has five states: IDLE, FETCH, EXEC, DRAIN and DONE.

- **IDLE**
  - Outputs drive a NOP: `instr`=0x00000013, all control signals 0, `ReadData`=0.
  - On `start`: clear all counters, set idx=0, go to FETCH.
- **FETCH**
  - `vec_addr`=idx and the drives hold the NOP.
  - At the end of the cycle, latch the `vec_*` inputs into the drive registers and go to EXEC.
- **EXEC**
  - The drives present the vector for exactly one cycle, and the datapath commits it at the closing edge.
  - At that edge, if check_en=1, the vector passes when `ALUResult`==`vec_expect` and `zero`==zero_exp.
    - On a pass, increment `pass_count`.
    - On a fail, increment `fail_count`, and record idx in `first_fail` if this is the first failure.
  - If check_en=0, neither counter changes.
  - If idx==NUM_TESTS-1, go to DRAIN. Otherwise increment idx and go to FETCH.
- **DRAIN**
  - One NOP cycle, used for the final PC check.
  - Then go to DONE.
- **DONE**
  - `done`=1 and `pass`=(`fail_count`==0). Hold there.
  - `start` restarts the run: clear all counters, set idx=0, go to FETCH.

Further rules:
- `busy` is high in FETCH, EXEC and DRAIN.
- The counters saturate at 2^CW-1 and never wrap.
- A `start` pulse while `busy` is ignored.
- Comparisons are exact XLEN-bit equality. Sign has no meaning; -5 is expected as 0xFFFFFFFB.

## Timing
- Reset (asynchronous) forces:
  - state=IDLE and idx=0.
  - All counters, `first_fail` and `vec_addr` to 0.
  - `busy`, `done` and `pass` to 0.
  - Drives to the NOP values.
- Reset asserted mid-run aborts the run immediately and leaves no partial results.
- Vector ROM read latency is exactly 1 cycle.
- Each vector takes 2 cycles (FETCH then EXEC).
- If `start` is sampled at edge 0, EXEC of vector k spans cycle 2k+2. DRAIN is cycle 2·NUM_TESTS+1, and `done` rises at the following edge.
- Only EXEC cycles can carry a nonzero `RegWrite` or `PCSrc`. FETCH and DRAIN never write the register file.

## Configuration
- `DATAPATH_BIST_PC_CHECK_EN` defined:
  - In the cycle after each EXEC (FETCH or DRAIN), check the PC.
    - If the vector had PCSrc=0, the required PC is the EXEC-cycle PC plus 4.
    - If the vector had PCSrc=1, the PC must differ from the EXEC-cycle PC.
  - A PC mismatch increments `fail_count`, even when check_en=0, and updates `first_fail` under the same first-failure rule.
- `DATAPATH_BIST_PC_CHECK_EN` undefined: the PC is ignored, `PC` is left unused and no PC logic is synthesized.

## Test plan
- Vectors: addi x2,x0,5 expecting 5; addi x3,x0,10 expecting 10; add x1,x2,x3 expecting 15; sub x4,x2,x3 expecting 0xFFFFFFFB. With NUM_TESTS=4 → `done` at cycle 10, `pass`=1, `pass_count`=4, `fail_count`=0.
- Same set with vector 2 expecting 16 → `fail_count`=1, `first_fail`=2, `pass`=0.
- sub x7,x2,x2 with zero_exp=1 expecting 0 → passes. The same vector with zero_exp=0 → fails.
- Vector with check_en=0 → neither counter changes. `start` pulsed while `busy` → the run is unaffected.
- Reset asserted during EXEC of vector 1 → all outputs return to reset values at once. A later `start` runs the full set from idx 0.
- With `DATAPATH_BIST_PC_CHECK_EN` defined, a datapath model whose PC is stuck → every vector with PCSrc=0 increments `fail_count`.
